// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-2 demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

    // Each lane buffers up to two words so one stalled lane never blocks the other.
    localparam int FIFO_DEPTH = 2;

    // Lane index and FIFO pointer width: a single bit covers the two lanes and the two slots.
    typedef logic lane_t;

    // Occupancy count 0..2 needs two bits.
    typedef logic [1:0] fifo_cnt_t;

    localparam fifo_cnt_t CNT_EMPTY = 2'd0;
    localparam fifo_cnt_t CNT_FULL  = 2'(FIFO_DEPTH);

    // Lane selection: alternate via the toggle in auto mode, otherwise follow the per-word select.
    function automatic lane_t pick_lane(input logic auto_mode, input lane_t toggle_lane,
                                        input lane_t sel_lane);
        return auto_mode ? toggle_lane : sel_lane;
    endfunction

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry FIFO for one output lane of the demultiplexer.
// Latency: a word pushed at edge N is at the head (valid) after edge N; push+pop at count 1 keeps count.
// Backpressure: full is purely registered; a same-cycle pop does not free space for a same-cycle push.
module lane_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    lane_t            rd_ptr;
    lane_t            wr_ptr;
    fifo_cnt_t        count;
    logic             do_push;
    logic             do_pop;

    // Status flags come straight from the registered count; head word is read from the read slot.
    always_comb begin
        full    = (count == CNT_FULL);
        valid   = (count != CNT_EMPTY);
        dout    = mem[rd_ptr];
        // Guard against a caller pushing into a full FIFO or popping an empty one.
        do_push = push && !full;
        do_pop  = pop && valid;
    end

    // Pointer and occupancy bookkeeping; 1-bit pointers wrap 1->0 on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= CNT_EMPTY;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; cleared on reset so the idle head word reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Occupancy must stay within 0..2.
    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_FULL);

    // The enclosing handshake must never offer a push to a full lane.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

    // A pop is only offered while a word is present.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && !valid));

endmodule

// File: rtl/demux1to2_buf.sv
// Buffered 1-to-2 demultiplexer: routes each input word to lane 0 or 1 (per-word select or auto-alternate).
// Latency: one cycle from input acceptance to the word being valid at an empty lane's output.
// Backpressure: in_ready drops only when the target lane is full; the other lane keeps flowing.
module demux1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             auto,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             toggle
);

    lane_t tgt;
    logic  full0;
    logic  full1;
    logic  in_xfer;
    logic  push0;
    logic  push1;
    logic  pop0;
    logic  pop1;

    // Target lane selection and handshake gating; ready looks only at the registered full flag.
    always_comb begin
        tgt      = pick_lane(auto, toggle, in_sel);
        in_ready = (tgt == 1'b1) ? !full1 : !full0;
        in_xfer  = in_valid && in_ready;
        push0    = in_xfer && (tgt == 1'b0);
        push1    = in_xfer && (tgt == 1'b1);
        pop0     = out0_valid && out0_ready;
        pop1     = out1_valid && out1_ready;
    end

    // Auto-mode lane pointer: advances only on words actually accepted while auto is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle <= 1'b0;
        end else if (in_xfer && auto) begin
            toggle <= ~toggle;
        end
    end

    lane_fifo2 #(
        .WIDTH (WIDTH)
    ) u_lane0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .din   (in_data),
        .pop   (pop0),
        .dout  (out0_data),
        .valid (out0_valid),
        .full  (full0)
    );

    lane_fifo2 #(
        .WIDTH (WIDTH)
    ) u_lane1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .din   (in_data),
        .pop   (pop1),
        .dout  (out1_data),
        .valid (out1_valid),
        .full  (full1)
    );

endmodule

// File: tb/tb_demux1to2_buf.sv
// Directed bench for demux1to2_buf: routing, alternation, backpressure, push+pop and reset.
// Inputs change 1 time unit after each rising edge; outputs are compared 1 unit later.
// All expected values are hand-derived constants per scenario.
module tb_demux1to2_buf;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       auto;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic       toggle;

    int checks = 0;
    int errors = 0;

    demux1to2_buf #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .auto       (auto),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .toggle     (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs may then be driven safely.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after inputs are driven.
    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = 0; in_sel = 0; auto = 0; out0_ready = 0; out1_ready = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid: got %b want 0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid: got %b want 0", out1_valid); end
        checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b want 0", toggle); end
        checks++; if (out0_data !== 8'h00) begin errors++; $display("FAIL reset_out0_data: got %h want 00", out0_data); end
        // Fill lane 0 with two words, then reset with a word still offered.
        tick();
        drive(1, 8'h5A, 0); tick();
        drive(1, 8'h5B, 0); tick();
        drive(1, 8'h5C, 0); settle();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h5A) begin errors++; $display("FAIL reset_fill_head: got v=%b d=%h want v=1 d=5a", out0_valid, out0_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_fill_full: got in_ready=%b want 0", in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 8'h00, 0);
        settle();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL reset_flush_valid: got %b%b want 00", out0_valid, out1_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_flush_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_explicit_routing();
        auto = 0; out0_ready = 1; out1_ready = 1;
        drive(1, 8'hA1, 0); settle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready_a1: got %b want 1", in_ready); end
        tick();
        drive(1, 8'hB2, 1); settle();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA1) begin errors++; $display("FAIL route_out0_a1: got v=%b d=%h want v=1 d=a1", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_idle: got %b want 0", out1_valid); end
        tick();
        drive(1, 8'hC3, 0); settle();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'hB2) begin errors++; $display("FAIL route_out1_b2: got v=%b d=%h want v=1 d=b2", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL route_out0_popped: got %b want 0", out0_valid); end
        tick();
        drive(0, 8'h00, 0); settle();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hC3) begin errors++; $display("FAIL route_out0_c3: got v=%b d=%h want v=1 d=c3", out0_valid, out0_data); end
        tick();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL route_drained: got %b%b want 00", out0_valid, out1_valid); end
        checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL route_toggle_fixed: got %b want 0", toggle); end
    endtask

    task automatic test_auto_alternation();
        logic [7:0] words [4];
        logic       exp_tog [5];
        words[0] = 8'h10; words[1] = 8'h11; words[2] = 8'h12; words[3] = 8'h13;
        exp_tog[0] = 0; exp_tog[1] = 1; exp_tog[2] = 0; exp_tog[3] = 1; exp_tog[4] = 0;
        auto = 1; out0_ready = 1; out1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, words[i], 1'b1); settle();
            checks++; if (toggle !== exp_tog[i]) begin errors++; $display("FAIL auto_toggle_%0d: got %b want %b", i, toggle, exp_tog[i]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL auto_ready_%0d: got %b want 1", i, in_ready); end
            tick();
            if (i[0] == 1'b0) begin
                checks++; if (out0_valid !== 1'b1 || out0_data !== words[i]) begin errors++; $display("FAIL auto_out0_%0d: got v=%b d=%h want v=1 d=%h", i, out0_valid, out0_data, words[i]); end
            end else begin
                checks++; if (out1_valid !== 1'b1 || out1_data !== words[i]) begin errors++; $display("FAIL auto_out1_%0d: got v=%b d=%h want v=1 d=%h", i, out1_valid, out1_data, words[i]); end
            end
        end
        drive(0, 8'h00, 0); settle();
        checks++; if (toggle !== exp_tog[4]) begin errors++; $display("FAIL auto_toggle_end: got %b want %b", toggle, exp_tog[4]); end
        tick();
        auto = 0;
    endtask

    task automatic test_backpressure();
        auto = 0; out0_ready = 0; out1_ready = 1;
        drive(1, 8'h01, 0); tick();
        drive(1, 8'h02, 0); tick();
        drive(1, 8'h03, 0); settle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out0_data !== 8'h01) begin errors++; $display("FAIL bp_hold: got rdy=%b d=%h want rdy=0 d=01", in_ready, out0_data); end
        // Lane 1 still accepts while lane 0 is stalled.
        drive(1, 8'h55, 1); settle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_lane1_ready: got %b want 1", in_ready); end
        tick();
        drive(1, 8'h03, 0); settle();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h55) begin errors++; $display("FAIL bp_lane1_data: got v=%b d=%h want v=1 d=55", out1_valid, out1_data); end
        out0_ready = 1; settle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_passthru: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1 || out0_data !== 8'h02) begin errors++; $display("FAIL bp_after_pop: got rdy=%b d=%h want rdy=1 d=02", in_ready, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL bp_lane1_drained: got %b want 0", out1_valid); end
        tick();
        drive(0, 8'h00, 0); settle();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h03) begin errors++; $display("FAIL bp_out0_03: got v=%b d=%h want v=1 d=03", out0_valid, out0_data); end
        tick();
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out0_valid); end
    endtask

    task automatic test_simul_push_pop();
        auto = 0; out0_ready = 1; out1_ready = 0;
        drive(1, 8'h66, 1); tick();
        drive(0, 8'h00, 1); settle();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h66) begin errors++; $display("FAIL pp_head_66: got v=%b d=%h want v=1 d=66", out1_valid, out1_data); end
        drive(1, 8'h77, 1); out1_ready = 1; tick();
        drive(0, 8'h00, 1); settle();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h77) begin errors++; $display("FAIL pp_head_77: got v=%b d=%h want v=1 d=77", out1_valid, out1_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_not_full: got %b want 1", in_ready); end
        tick();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL pp_count_one: got v=%b want 0", out1_valid); end
    endtask

    task automatic test_auto_stall();
        do_reset();
        auto = 1; out0_ready = 0; out1_ready = 1;
        drive(1, 8'hA0, 0); tick();
        drive(1, 8'hA1, 0); tick();
        drive(1, 8'hA2, 0); tick();
        drive(1, 8'hA3, 0); tick();
        drive(1, 8'hA4, 0); settle();
        checks++; if (toggle !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_blocked: got tog=%b rdy=%b want tog=0 rdy=0", toggle, in_ready); end
        tick();
        tick();
        checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL stall_toggle_frozen: got %b want 0", toggle); end
        // Switch to explicit routing: lane 1 word goes through, toggle stays put.
        auto = 0; drive(1, 8'hB0, 1); settle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_manual_ready: got %b want 1", in_ready); end
        tick();
        drive(0, 8'h00, 0); settle();
        checks++; if (toggle !== 1'b0) begin errors++; $display("FAIL stall_manual_toggle: got %b want 0", toggle); end
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'hB0) begin errors++; $display("FAIL stall_manual_data: got v=%b d=%h want v=1 d=b0", out1_valid, out1_data); end
        auto = 1; drive(1, 8'hA4, 0); settle();
        checks++; if (in_ready !== 1'b0 || out0_data !== 8'hA0) begin errors++; $display("FAIL stall_lane0_held: got rdy=%b d=%h want rdy=0 d=a0", in_ready, out0_data); end
        drive(0, 8'h00, 0); out0_ready = 1; tick();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA2) begin errors++; $display("FAIL stall_lane0_order: got v=%b d=%h want v=1 d=a2", out0_valid, out0_data); end
        tick();
        auto = 0;
    endtask

    initial begin
        test_reset();
        test_explicit_routing();
        test_auto_alternation();
        test_backpressure();
        test_simul_push_pop();
        test_auto_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
